// File: rtl/ball_motion_pkg.sv
// rtl/ball_motion_pkg.sv - playfield geometry, state encodings and shared types for the Pong ball
package ball_motion_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int BALL_SIZE  = 8;
    localparam int PADDLE_H   = 64;
    localparam int PADDLE_W   = 8;
    localparam int PADDLE_XL  = 16;
    localparam int PADDLE_XR  = 616;
    localparam int SPEED      = 2;
    localparam int HOLD_TICKS = 60;
    localparam int SCORE_W    = 4;
    localparam int HOLD_W     = $clog2(HOLD_TICKS);

    typedef logic signed [11:0] coord_t;
    typedef logic [9:0]         pos_t;
    typedef logic [SCORE_W-1:0] score_t;
    typedef logic [HOLD_W-1:0]  hold_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PLAY   = 2'd1;
    localparam logic [1:0] ST_SCORED = 2'd2;

    // Signed working-width constants so every comparison happens before truncation.
    localparam coord_t SPEED_C     = coord_t'(SPEED);
    localparam coord_t BALL_C      = coord_t'(BALL_SIZE);
    localparam coord_t PADDLE_H_C  = coord_t'(PADDLE_H);
    localparam coord_t PADDLE_XL_C = coord_t'(PADDLE_XL);
    localparam coord_t L_FACE_C    = coord_t'(PADDLE_XL + PADDLE_W);
    localparam coord_t PADDLE_XR_C = coord_t'(PADDLE_XR);
    localparam coord_t R_FACE_C    = coord_t'(PADDLE_XR + PADDLE_W);
    localparam coord_t R_STOP_C    = coord_t'(PADDLE_XR - BALL_SIZE);
    localparam coord_t X_MAX_C     = coord_t'(SCREEN_W - BALL_SIZE);
    localparam coord_t Y_MAX_C     = coord_t'(SCREEN_H - BALL_SIZE);

    localparam pos_t  CENTER_X  = pos_t'((SCREEN_W - BALL_SIZE) / 2);
    localparam pos_t  CENTER_Y  = pos_t'((SCREEN_H - BALL_SIZE) / 2);
    localparam hold_t HOLD_LAST = hold_t'(HOLD_TICKS - 1);

    // Direction bits are "moving toward smaller coordinate".
    typedef struct packed {
        pos_t x;
        pos_t y;
        logic dx_neg;
        logic dy_neg;
    } ball_t;

    typedef struct packed {
        logic hit_l;
        logic hit_r;
        logic miss_l;
        logic miss_r;
    } step_evt_t;

    function automatic coord_t widen(input pos_t p);
        return $signed({2'b00, p});
    endfunction

    function automatic score_t sat_inc(input score_t s);
        return (&s) ? s : s + 1'b1;
    endfunction

endpackage

// File: rtl/ball_motion_if.sv
// rtl/ball_motion_if.sv - game-tick, paddle and ball/score signals between game logic and its peers
interface ball_motion_if;
    import ball_motion_pkg::*;

    logic   tick;
    logic   serve;
    pos_t   paddle_l_y;
    pos_t   paddle_r_y;
    pos_t   ball_x;
    pos_t   ball_y;
    score_t score_l;
    score_t score_r;
    logic   point;
    logic   in_play;

    modport master (
        output tick, serve, paddle_l_y, paddle_r_y,
        input  ball_x, ball_y, score_l, score_r, point, in_play
    );

    modport slave (
        input  tick, serve, paddle_l_y, paddle_r_y,
        output ball_x, ball_y, score_l, score_r, point, in_play
    );

endinterface

// File: rtl/ball_motion_step.sv
// rtl/ball_motion_step.sv - one-tick ball advance: walls, paddle hits and misses
module ball_motion_step
    import ball_motion_pkg::*;
(
    input  ball_t     cur,
    input  pos_t      paddle_l_y,
    input  pos_t      paddle_r_y,
    output ball_t     nxt,
    output step_evt_t evt
);

    coord_t nx;
    coord_t ny;
    coord_t pl;
    coord_t pr;
    logic   zone_l;
    logic   zone_r;
    logic   over_l;
    logic   over_r;
    logic   hit_l;
    logic   hit_r;
    logic   miss_l;
    logic   miss_r;

    assign pl = widen(paddle_l_y);
    assign pr = widen(paddle_r_y);
    assign nx = cur.dx_neg ? widen(cur.x) - SPEED_C : widen(cur.x) + SPEED_C;
    assign ny = cur.dy_neg ? widen(cur.y) - SPEED_C : widen(cur.y) + SPEED_C;

    // Paddle zones only count when the ball is heading into that paddle.
    assign zone_l = cur.dx_neg && (nx <= L_FACE_C) && (nx + BALL_C > PADDLE_XL_C);
    assign zone_r = !cur.dx_neg && (nx + BALL_C >= PADDLE_XR_C) && (nx < R_FACE_C);
    assign over_l = (ny < pl + PADDLE_H_C) && (ny + BALL_C > pl);
    assign over_r = (ny < pr + PADDLE_H_C) && (ny + BALL_C > pr);

    assign hit_l  = zone_l && over_l;
    assign hit_r  = zone_r && over_r;
    assign miss_l = !hit_l && (nx <= 12'sd0);
    assign miss_r = !hit_r && (nx >= X_MAX_C);

    assign evt = '{hit_l: hit_l, hit_r: hit_r, miss_l: miss_l, miss_r: miss_r};

    always_comb begin
        nxt = cur;

        if (ny <= 12'sd0) begin
            nxt.y      = '0;
            nxt.dy_neg = 1'b0;
        end else if (ny >= Y_MAX_C) begin
            nxt.y      = pos_t'(Y_MAX_C);
            nxt.dy_neg = 1'b1;
        end else begin
            nxt.y = pos_t'(ny);
        end

        // After a miss dx already points at the loser for the next serve.
        if (hit_l) begin
            nxt.x      = pos_t'(L_FACE_C);
            nxt.dx_neg = 1'b0;
        end else if (hit_r) begin
            nxt.x      = pos_t'(R_STOP_C);
            nxt.dx_neg = 1'b1;
        end else if (miss_l) begin
            nxt.x      = '0;
            nxt.dx_neg = 1'b1;
        end else if (miss_r) begin
            nxt.x      = pos_t'(X_MAX_C);
            nxt.dx_neg = 1'b0;
        end else begin
            nxt.x = pos_t'(nx);
        end
    end

endmodule

// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - Pong ball game logic: serve/play/hold FSM, scoring, per-tick ball advance
module ball_motion
    import ball_motion_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    ball_motion_if.slave  bus
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    ball_t      ball_q;
    ball_t      ball_d;
    hold_t      hold_q;
    hold_t      hold_d;
    score_t     score_l_q;
    score_t     score_l_d;
    score_t     score_r_q;
    score_t     score_r_d;
    logic       point_q;
    logic       point_d;

    ball_t      step_nxt;
    step_evt_t  step_evt;
    logic       scored_l;
    logic       scored_r;

    ball_motion_step u_step (
        .cur        (ball_q),
        .paddle_l_y (bus.paddle_l_y),
        .paddle_r_y (bus.paddle_r_y),
        .nxt        (step_nxt),
        .evt        (step_evt)
    );

    // A miss past the left edge is a point for the right player and vice versa.
    assign scored_r = step_evt.miss_l && !step_evt.hit_l;
    assign scored_l = step_evt.miss_r && !step_evt.hit_r;

    always_comb begin
        state_d   = state_q;
        ball_d    = ball_q;
        hold_d    = hold_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        point_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.serve) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (bus.tick) begin
                    ball_d = step_nxt;
                    if (scored_l || scored_r) begin
                        state_d = ST_SCORED;
                        point_d = 1'b1;
                        hold_d  = '0;
                    end
                    if (scored_r) begin
                        score_r_d = sat_inc(score_r_q);
                    end
                    if (scored_l) begin
                        score_l_d = sat_inc(score_l_q);
                    end
                end
            end
            ST_SCORED: begin
                if (bus.tick) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d  = ST_IDLE;
                        hold_d   = '0;
                        ball_d.x = CENTER_X;
                        ball_d.y = CENTER_Y;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ball_q    <= '{x: CENTER_X, y: CENTER_Y, dx_neg: 1'b0, dy_neg: 1'b0};
            hold_q    <= '0;
            score_l_q <= '0;
            score_r_q <= '0;
            point_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ball_q    <= ball_d;
            hold_q    <= hold_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            point_q   <= point_d;
        end
    end

    assign bus.ball_x  = ball_q.x;
    assign bus.ball_y  = ball_q.y;
    assign bus.score_l = score_l_q;
    assign bus.score_r = score_r_q;
    assign bus.point   = point_q;
    assign bus.in_play = (state_q == ST_PLAY);

endmodule
